// File: rtl/game_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_ctrl_pkg
// Shared definitions for the cellular-game controller: the state encoding
// (also used by the debug/LED decoder) and the default parameter values.
// ---------------------------------------------------------------------------
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_LOSE     = 3'b001,
    ST_LOAD     = 3'b010,
    ST_READ     = 3'b011,
    ST_WRITEOUT = 3'b100,
    ST_PAUSE    = 3'b101,
    ST_WIN      = 3'b110,
    ST_RESTART  = 3'b111
  } state_t;

  localparam int DEF_CNT_W       = 9;
  localparam int DEF_LOAD_CYCLES = 15;
  localparam int DEF_READ_CYCLES = 256;
  localparam int DEF_GEN_W       = 15;
  localparam int DEF_WIN_GENS    = 26111;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous reset, synchronous clear and increment enable.
// With SATURATE set the counter holds at all-ones instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (value -> 0)
//   clr   - synchronous clear, wins over inc
//   inc   - increment enable
//   value - current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next count: clear first, then increment unless pinned at all-ones
  // in saturating mode.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      if (!(SATURATE && (&value_q))) begin
        value_d = value_q + WIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// game_ctrl_fsm
// Sequencer for the cellular-game datapath: board load, timed read/compute
// iterations, one-cycle write-back, pause, single-step and win/lose ends.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   inp                 - new-game request (level)
//   run                 - free-run enable
//   wai                 - pause request
//   step                - single-iteration request (1-cycle pulse)
//   lose_sig            - loss event from the datapath
//   load_data, read_data, writeout, restart, win, lose
//                       - Moore decodes of the current state
//   state               - raw state encoding
//   count               - phase counter (non-zero only in LOAD/READ)
//   gen_count           - completed generations, saturating
// ---------------------------------------------------------------------------
module game_ctrl_fsm #(
  parameter int CNT_W       = game_ctrl_pkg::DEF_CNT_W,
  parameter int LOAD_CYCLES = game_ctrl_pkg::DEF_LOAD_CYCLES,
  parameter int READ_CYCLES = game_ctrl_pkg::DEF_READ_CYCLES,
  parameter int GEN_W       = game_ctrl_pkg::DEF_GEN_W,
  parameter int WIN_GENS    = game_ctrl_pkg::DEF_WIN_GENS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             run,
  input  logic             wai,
  input  logic             step,
  input  logic             lose_sig,
  output logic             load_data,
  output logic             read_data,
  output logic             writeout,
  output logic             restart,
  output logic             win,
  output logic             lose,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] count,
  output logic [GEN_W-1:0] gen_count
);

  import game_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [GEN_W-1:0] WIN_VAL   = GEN_W'(WIN_GENS);

  state_t           state_q;
  state_t           state_d;
  logic             loseFlag_q;
  logic             loseFlag_d;
  logic             cntClr;
  logic             cntInc;
  logic             genClr;
  logic             genInc;
  logic [CNT_W-1:0] cntVal;
  logic [GEN_W-1:0] genVal;

  // State and pending-loss registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      loseFlag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      loseFlag_q <= loseFlag_d;
    end
  end

  // Next-state logic. A new-game request overrides every state, including
  // the terminal ones. IDLE is the only decision point for run/step/wai, so
  // requests seen elsewhere are either dropped (step) or deferred (wai).
  always_comb begin
    state_d = state_q;
    if (inp) begin
      state_d = ST_RESTART;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (loseFlag_q || lose_sig) begin
            state_d = ST_LOSE;
          end else if (genVal == WIN_VAL) begin
            state_d = ST_WIN;
          end else if (wai) begin
            state_d = ST_PAUSE;
          end else if (run || step) begin
            state_d = ST_READ;
          end
        end
        ST_LOAD: begin
          if (cntVal == LOAD_LAST) begin
            state_d = ST_IDLE;
          end
        end
        ST_READ: begin
          if (cntVal == READ_LAST) begin
            state_d = ST_WRITEOUT;
          end
        end
        ST_WRITEOUT: state_d = ST_IDLE;
        ST_PAUSE: begin
          if (loseFlag_q || lose_sig) begin
            state_d = ST_LOSE;
          end else if (!wai) begin
            state_d = ST_IDLE;
          end
        end
        ST_RESTART: state_d = ST_LOAD;
        default:    state_d = state_q;
      endcase
    end
  end

  // Counter controls and the pending-loss flag. Any state change clears the
  // phase counter, so every LOAD/READ phase starts from zero and the counter
  // stays zero elsewhere. Clearing on entry to RESTART makes the cleared
  // generation count and loss flag visible already in the RESTART cycle.
  always_comb begin
    loseFlag_d = loseFlag_q;
    if (state_d == ST_RESTART) begin
      loseFlag_d = 1'b0;
    end else if (lose_sig && (state_q inside {ST_LOAD, ST_READ, ST_WRITEOUT})) begin
      loseFlag_d = 1'b1;
    end
    cntClr = (state_d != state_q);
    cntInc = (state_q inside {ST_LOAD, ST_READ});
    genClr = (state_d == ST_RESTART);
    genInc = (state_q == ST_WRITEOUT);
  end

  sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_phaseCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cntClr),
    .inc   (cntInc),
    .value (cntVal)
  );

  sat_counter #(
    .WIDTH    (GEN_W),
    .SATURATE (1'b1)
  ) u_genCnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (genClr),
    .inc   (genInc),
    .value (genVal)
  );

  assign load_data = (state_q == ST_LOAD);
  assign read_data = (state_q == ST_READ);
  assign writeout  = (state_q == ST_WRITEOUT);
  assign restart   = (state_q == ST_RESTART);
  assign win       = (state_q == ST_WIN);
  assign lose      = (state_q == ST_LOSE);
  assign state     = state_q;
  assign count     = cntVal;
  assign gen_count = genVal;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl_fsm
// Directed bench for game_ctrl_fsm with short phases: LOAD_CYCLES=4,
// READ_CYCLES=8, WIN_GENS=3. A vector table covers new game, load and
// single-step iterations; hand-written sequences cover reset mid-READ,
// free-run to WIN, deferred loss, lose-over-win and pause.
// ---------------------------------------------------------------------------
module tb_game_ctrl_fsm;

  import game_ctrl_pkg::*;

  localparam int CNT_W       = 9;
  localparam int GEN_W       = 15;
  localparam int LOAD_CYCLES = 4;
  localparam int READ_CYCLES = 8;
  localparam int WIN_GENS    = 3;
  localparam int OUT_W       = 6 + 3 + CNT_W + GEN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             inp;
  logic             run;
  logic             wai;
  logic             step;
  logic             loseSig;
  logic             loadData;
  logic             readData;
  logic             writeout;
  logic             restart;
  logic             win;
  logic             lose;
  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic [GEN_W-1:0] genCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic   inp;
    logic   run;
    logic   wai;
    logic   step;
    logic   loseSig;
    state_t expState;
    int     expCount;
    int     expGen;
  } vec_t;

  vec_t vecs[$];
  int   woCycles[$];

  game_ctrl_fsm #(
    .CNT_W       (CNT_W),
    .LOAD_CYCLES (LOAD_CYCLES),
    .READ_CYCLES (READ_CYCLES),
    .GEN_W       (GEN_W),
    .WIN_GENS    (WIN_GENS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inp       (inp),
    .run       (run),
    .wai       (wai),
    .step      (step),
    .lose_sig  (loseSig),
    .load_data (loadData),
    .read_data (readData),
    .writeout  (writeout),
    .restart   (restart),
    .win       (win),
    .lose      (lose),
    .state     (state),
    .count     (count),
    .gen_count (genCount)
  );

  always #5 clk = ~clk;

  // Expected output vector: each 1-bit strobe is high only in its own state.
  function automatic logic [OUT_W-1:0] expVec(input state_t s, input int c, input int g);
    logic [2:0]       sv;
    logic [CNT_W-1:0] cv;
    logic [GEN_W-1:0] gv;
    sv = s;
    cv = CNT_W'(c);
    gv = GEN_W'(g);
    return {s == ST_LOAD, s == ST_READ, s == ST_WRITEOUT, s == ST_RESTART,
            s == ST_WIN, s == ST_LOSE, sv, cv, gv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic i, input logic r, input logic w,
                               input logic s, input logic l);
    inp     = i;
    run     = r;
    wai     = w;
    step    = s;
    loseSig = l;
  endtask

  task automatic checkOutput(input string name, input state_t s, input int c, input int g);
    logic [OUT_W-1:0] act;
    logic [OUT_W-1:0] exp;
    act = {loadData, readData, writeout, restart, win, lose, state, count, genCount};
    exp = expVec(s, c, g);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d count=%0d gen=%0d flags=%b, expected state=%0d count=%0d gen=%0d flags=%b",
               name, state, count, genCount,
               {loadData, readData, writeout, restart, win, lose},
               exp[CNT_W+GEN_W +: 3], c, g, exp[OUT_W-1 -: 6]);
    end
  endtask

  task automatic addVec(input logic i, input logic r, input logic w, input logic s,
                        input logic l, input state_t es, input int ec, input int eg);
    vec_t v;
    v.inp      = i;
    v.run      = r;
    v.wai      = w;
    v.step     = s;
    v.loseSig  = l;
    v.expState = es;
    v.expCount = ec;
    v.expGen   = eg;
    vecs.push_back(v);
  endtask

  // Pulse inp for one cycle and walk through RESTART and LOAD to IDLE.
  task automatic newGame(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput({tag, " restart"}, ST_RESTART, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (LOAD_CYCLES + 1) tick();
    checkOutput({tag, " idle after load"}, ST_IDLE, 0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", ST_IDLE, 0, 0);
    rst = 1'b0;

    // New game, load, then two single-step iterations with a dropped step
    // pulse in the middle of the first READ phase.
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ST_RESTART, 0, 0);
    for (int k = 0; k < LOAD_CYCLES; k++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_LOAD, k, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_READ, 0, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_READ, 1, 0);
    for (int k = 2; k < READ_CYCLES; k++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_READ, k, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_WRITEOUT, 0, 0);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ST_READ, 0, 1);
    for (int k = 1; k < READ_CYCLES; k++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_READ, k, 1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_WRITEOUT, 0, 1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 2);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 2);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].inp, vecs[i].run, vecs[i].wai, vecs[i].step, vecs[i].loseSig);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expCount, vecs[i].expGen);
    end

    // Reset in the middle of READ aborts the iteration with no write-back.
    newGame("rstmid");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("rstmid read5", ST_READ, 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid reset", ST_IDLE, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("rstmid idle%0d", k), ST_IDLE, 0, 0);
    end

    // Free run: write-backs at cycles 9, 19, 29 after run is applied, then WIN.
    newGame("win");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    woCycles.delete();
    for (int cyc = 1; cyc <= 31; cyc++) begin
      tick();
      if (writeout) woCycles.push_back(cyc);
      if (cyc == 10 || cyc == 20 || cyc == 30) begin
        checkOutput($sformatf("win idle at %0d", cyc), ST_IDLE, 0, cyc / 10);
      end
    end
    checkOutput("win reached", ST_WIN, 0, WIN_GENS);
    total++;
    if (woCycles.size() != 3 || woCycles[0] != 9 || woCycles[1] != 19 || woCycles[2] != 29) begin
      bad++;
      $display("[TB] FAIL writeout timing: got %0d pulses first=%0d, expected pulses at 9,19,29",
               woCycles.size(), (woCycles.size() > 0) ? woCycles[0] : -1);
    end
    repeat (5) tick();
    checkOutput("win held", ST_WIN, 0, WIN_GENS);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("win exit restart", ST_RESTART, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (LOAD_CYCLES + 1) tick();
    checkOutput("win exit idle", ST_IDLE, 0, 0);

    // Loss pulse mid-READ: iteration finishes, one IDLE cycle, then LOSE.
    newGame("lose");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("lose read3", ST_READ, 3, 0);
    loseSig = 1'b1;
    tick();
    loseSig = 1'b0;
    repeat (3) tick();
    checkOutput("lose read7", ST_READ, 7, 0);
    tick();
    checkOutput("lose writeout", ST_WRITEOUT, 0, 0);
    tick();
    checkOutput("lose idle", ST_IDLE, 0, 1);
    tick();
    checkOutput("lose entered", ST_LOSE, 0, 1);
    repeat (4) tick();
    checkOutput("lose held", ST_LOSE, 0, 1);

    // Loss latched on the final write-back beats the win at the same IDLE.
    newGame("prio");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (29) tick();
    checkOutput("prio writeout3", ST_WRITEOUT, 0, 2);
    loseSig = 1'b1;
    tick();
    loseSig = 1'b0;
    checkOutput("prio idle", ST_IDLE, 0, 3);
    tick();
    checkOutput("prio lose", ST_LOSE, 0, 3);

    // Pause raised mid-READ takes effect after the write-back.
    newGame("pause");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("pause read2", ST_READ, 2, 0);
    wai = 1'b1;
    repeat (5) tick();
    checkOutput("pause read7", ST_READ, 7, 0);
    tick();
    checkOutput("pause writeout", ST_WRITEOUT, 0, 0);
    tick();
    checkOutput("pause idle", ST_IDLE, 0, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("pause hold%0d", k), ST_PAUSE, 0, 1);
    end
    wai = 1'b0;
    tick();
    checkOutput("pause release", ST_IDLE, 0, 1);
    tick();
    checkOutput("pause resume", ST_READ, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
